// File: rtl/dmem_pkg.sv
// Shared encodings and state type for the data-memory responder.
package dmem_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] DMEM_BYTE    = 2'd0;
  localparam logic [1:0] DMEM_HALF    = 2'd1;
  localparam logic [1:0] DMEM_WORD    = 2'd2;
  localparam logic [1:0] DMEM_ILLEGAL = 2'd3;

  localparam logic DMEM_CMD_RD = 1'b0;
  localparam logic DMEM_CMD_WR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } dmem_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the load/store unit (master) and the data memory (slave).
interface dmem_responder_if;
  import dmem_pkg::*;

  logic            dmem_req;
  logic            dmem_cmd;
  logic [1:0]      dmem_width;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_stall;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_resp;
  logic            dmem_err;
  logic            proto_err;

  modport master (
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata, dmem_stall,
    input  dmem_rdata, dmem_resp, dmem_err, proto_err
  );

  modport slave (
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata, dmem_stall,
    output dmem_rdata, dmem_resp, dmem_err, proto_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store enables/shift for the incoming request, and
// right-align plus zero-extend for the latched read word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]      wr_addr_lo,
  input  logic [1:0]      wr_width,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      rd_addr_lo,
  input  logic [1:0]      rd_width,
  input  logic [XLEN-1:0] rd_word,
  output logic [3:0]      byte_en,
  output logic [XLEN-1:0] wdata_sh,
  output logic [XLEN-1:0] rdata_al
);

  logic [XLEN-1:0] rd_sh;

  always_comb begin
    byte_en = 4'b1111;
    case (wr_width)
      DMEM_BYTE: byte_en = 4'b0001 << wr_addr_lo;
      DMEM_HALF: byte_en = 4'b0011 << wr_addr_lo;
      default:   byte_en = 4'b1111;
    endcase
  end

  assign wdata_sh = wdata << {wr_addr_lo, 3'b000};
  assign rd_sh    = rd_word >> {rd_addr_lo, 3'b000};

  always_comb begin
    rdata_al = '0;
    case (rd_width)
      DMEM_BYTE: rdata_al = {{(XLEN-8){1'b0}}, rd_sh[7:0]};
      DMEM_HALF: rdata_al = {{(XLEN-16){1'b0}}, rd_sh[15:0]};
      DMEM_WORD: rdata_al = rd_sh;
      default:   rdata_al = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory target: word array, fixed stall-extendable
// response latency, range/encoding error flag and sticky protocol-error flag.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE    = 32'h0000_0000,
  parameter int              DEPTH   = 1024,
  parameter int              LATENCY = 2
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [XLEN:0]    SPAN     = {1'b0, XLEN'(DEPTH)} << 2;

  dmem_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        cmd_q, cmd_d;
  logic [1:0]  width_q, width_d;
  logic [1:0]  addr_lo_q, addr_lo_d;
  logic        err_q, err_d;
  logic        proto_err_q, proto_err_d;

  logic            accept;
  logic            resp_fire;
  logic            req_err;
  logic            wr_en;
  logic [XLEN-1:0] offset;
  logic [IDX_W-1:0] idx;
  logic [3:0]      byte_en;
  logic [XLEN-1:0] wdata_sh;
  logic [XLEN-1:0] rdata_al;
  logic [XLEN-1:0] rd_word_q;
  logic [XLEN-1:0] mem [DEPTH];

  // Addresses below BASE wrap to a huge offset, so one compare covers both range ends.
  assign offset  = bus.dmem_addr - BASE;
  assign idx     = offset[IDX_W+1:2];
  assign req_err = (bus.dmem_width == DMEM_ILLEGAL) || ({1'b0, offset} >= SPAN);
  assign wr_en   = accept && (bus.dmem_cmd == DMEM_CMD_WR) && !req_err;

  dmem_lane_align u_align (
    .wr_addr_lo (bus.dmem_addr[1:0]),
    .wr_width   (bus.dmem_width),
    .wdata      (bus.dmem_wdata),
    .rd_addr_lo (addr_lo_q),
    .rd_width   (width_q),
    .rd_word    (rd_word_q),
    .byte_en    (byte_en),
    .wdata_sh   (wdata_sh),
    .rdata_al   (rdata_al)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    width_d     = width_q;
    addr_lo_d   = addr_lo_q;
    err_d       = err_q;
    proto_err_d = proto_err_q;
    accept      = 1'b0;
    resp_fire   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        accept = bus.dmem_req;
      end
      ST_WAIT: begin
        if (bus.dmem_req) proto_err_d = 1'b1;
        if (!bus.dmem_stall) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.dmem_stall) begin
          if (bus.dmem_req) proto_err_d = 1'b1;
        end else begin
          resp_fire = 1'b1;
          state_d   = ST_IDLE;
          accept    = bus.dmem_req;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      cmd_d     = bus.dmem_cmd;
      width_d   = bus.dmem_width;
      addr_lo_d = bus.dmem_addr[1:0];
      err_d     = req_err;
      cnt_d     = CNT_LOAD;
      state_d   = (LATENCY == 1) ? ST_RESP : ST_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cmd_q       <= DMEM_CMD_RD;
      width_q     <= DMEM_BYTE;
      addr_lo_q   <= '0;
      err_q       <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      width_q     <= width_d;
      addr_lo_q   <= addr_lo_d;
      err_q       <= err_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Array contents survive reset; the read word is captured at the accept edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
    if (accept) rd_word_q <= mem[idx];
  end

  assign bus.dmem_resp  = resp_fire;
  assign bus.dmem_err   = resp_fire && err_q;
  assign bus.dmem_rdata = (resp_fire && !err_q && (cmd_q == DMEM_CMD_RD)) ? rdata_al : '0;
  assign bus.proto_err  = proto_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference model with deadline-based
// response timing, directed scenarios with literal expectations, then random traffic.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam logic [31:0] BASE    = 32'h0000_0000;
  localparam int          DEPTH   = 1024;
  localparam int          LATENCY = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if bus ();

  dmem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     n_cmp = 0;
  int     n_fail = 0;
  longint cyc = 0;

  logic [7:0]  mmem [4*DEPTH];
  logic        m_pending = 1'b0;
  longint      m_due = 0;
  logic [31:0] m_data = '0;
  logic        m_err = 1'b0;
  logic        m_proto = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic req_is_err(input logic [1:0] w, input logic [31:0] a);
    longint la, lb;
    la = longint'({32'b0, a});
    lb = longint'({32'b0, BASE});
    return (w == 2'd3) || (la < lb) || (la - lb >= 4 * DEPTH);
  endfunction

  // Byte-granular memory: writes store 1/2/4 bytes, reads gather them little-endian.
  function automatic logic [31:0] model_access(input logic cmd, input logic [1:0] w,
                                               input logic [31:0] a, input logic [31:0] wd,
                                               input logic err);
    logic [31:0] v;
    int unsigned off;
    int n;
    v = '0;
    if (err) return '0;
    off = a - BASE;
    n = 1 << w;
    for (int k = 0; k < n; k++) begin
      if (cmd == DMEM_CMD_WR) mmem[off + k] = wd[8*k +: 8];
      else v[8*k +: 8] = mmem[off + k];
    end
    return (cmd == DMEM_CMD_WR) ? 32'h0 : v;
  endfunction

  always @(negedge clk) begin : compare_proc
    logic resp_now, do_accept, proto_next;
    cyc++;
    if (!rst) begin
      m_pending = 1'b0;
      m_proto   = 1'b0;
      check_output("reset resp", bus.dmem_resp, 0);
      check_output("reset rdata", bus.dmem_rdata, 0);
      check_output("reset err", bus.dmem_err, 0);
      check_output("reset proto_err", bus.proto_err, 0);
    end else begin
      resp_now   = 1'b0;
      do_accept  = 1'b0;
      proto_next = m_proto;
      if (m_pending) begin
        if (cyc == m_due) begin
          if (bus.dmem_stall) begin
            m_due++;
            if (bus.dmem_req) proto_next = 1'b1;
          end else begin
            resp_now  = 1'b1;
            m_pending = 1'b0;
            do_accept = bus.dmem_req;
          end
        end else begin
          if (bus.dmem_stall) m_due++;
          if (bus.dmem_req) proto_next = 1'b1;
        end
      end else begin
        do_accept = bus.dmem_req;
      end
      check_output("resp", bus.dmem_resp, resp_now);
      check_output("rdata", bus.dmem_rdata, resp_now ? m_data : 32'h0);
      check_output("err", bus.dmem_err, resp_now ? m_err : 1'b0);
      check_output("proto_err", bus.proto_err, m_proto);
      m_proto = proto_next;
      if (do_accept) begin
        m_err     = req_is_err(bus.dmem_width, bus.dmem_addr);
        m_data    = model_access(bus.dmem_cmd, bus.dmem_width, bus.dmem_addr, bus.dmem_wdata, m_err);
        m_pending = 1'b1;
        m_due     = cyc + LATENCY;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic cmd, input logic [1:0] w,
                       input logic [31:0] a, input logic [31:0] wd, input logic st);
    bus.dmem_req   = req;
    bus.dmem_cmd   = cmd;
    bus.dmem_width = w;
    bus.dmem_addr  = a;
    bus.dmem_wdata = wd;
    bus.dmem_stall = st;
  endtask

  task automatic txn(input string name, input logic cmd, input logic [1:0] w,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] d, output logic e, output int lat);
    step();
    drive(1'b1, cmd, w, a, wd, 1'b0);
    @(negedge clk);
    step();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    lat = 0;
    d   = 'x;
    e   = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.dmem_resp === 1'b1) begin
        lat = k;
        d   = bus.dmem_rdata;
        e   = bus.dmem_err;
        break;
      end
    end
    if (lat == 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s timeout: got no response, want one within 40 cycles", name);
    end
  endtask

  task automatic apply_stimulus(input string name, input logic cmd, input logic [1:0] w,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] d;
    logic e;
    int lat;
    txn(name, cmd, w, a, wd, d, e, lat);
    check_output({name, " latency"}, lat, LATENCY);
    check_output({name, " rdata"}, d, exp_d);
    check_output({name, " err"}, e, exp_e);
  endtask

  task automatic fill_word(input logic [31:0] a);
    logic [31:0] d;
    logic e;
    int lat;
    txn("fill", DMEM_CMD_WR, DMEM_WORD, a, $urandom, d, e, lat);
  endtask

  initial begin : watchdog
    #2000000;
    n_fail++;
    $display("[TB] FAIL watchdog: got no end of test, want finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : stim
    logic [31:0] a3 [3];
    logic [1:0]  w3 [3];
    logic [31:0] e3 [3];
    logic        st, can;
    logic [1:0]  w;
    logic [31:0] a;
    int          r, wsel;

    rst = 1'b0;
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    check_output("por resp", bus.dmem_resp, 0);
    check_output("por proto_err", bus.proto_err, 0);
    step();
    rst = 1'b1;

    $display("[TB] word store then load");
    apply_stimulus("t1 sw", DMEM_CMD_WR, DMEM_WORD, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    apply_stimulus("t1 lw", DMEM_CMD_RD, DMEM_WORD, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    $display("[TB] byte merge");
    apply_stimulus("t2 sw", DMEM_CMD_WR, DMEM_WORD, 32'h10, 32'h11223344, 32'h0, 1'b0);
    apply_stimulus("t2 sb", DMEM_CMD_WR, DMEM_BYTE, 32'h13, 32'hFFFFFFA5, 32'h0, 1'b0);
    apply_stimulus("t2 lb", DMEM_CMD_RD, DMEM_BYTE, 32'h13, 32'h0, 32'h000000A5, 1'b0);
    apply_stimulus("t2 lw", DMEM_CMD_RD, DMEM_WORD, 32'h10, 32'h0, 32'hA5223344, 1'b0);

    $display("[TB] back-to-back reads");
    a3 = '{32'h10, 32'h12, 32'h13};
    w3 = '{DMEM_WORD, DMEM_HALF, DMEM_BYTE};
    e3 = '{32'hA5223344, 32'h0000A522, 32'h000000A5};
    for (int k = 0; k <= 6; k++) begin
      step();
      if ((k % 2 == 0) && (k < 6)) drive(1'b1, DMEM_CMD_RD, w3[k/2], a3[k/2], 32'h0, 1'b0);
      else drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      if (k > 0) check_output($sformatf("t3 resp c+%0d", k), bus.dmem_resp, (k % 2 == 0));
      if (k > 0 && (k % 2 == 0)) check_output($sformatf("t3 rdata c+%0d", k), bus.dmem_rdata, e3[k/2 - 1]);
    end
    check_output("t3 proto_err", bus.proto_err, 0);

    $display("[TB] range and encoding errors");
    apply_stimulus("t4 sw0", DMEM_CMD_WR, DMEM_WORD, 32'h0, 32'h0BADF00D, 32'h0, 1'b0);
    apply_stimulus("t4 lw oob", DMEM_CMD_RD, DMEM_WORD, 32'h1000, 32'h0, 32'h0, 1'b1);
    apply_stimulus("t4 sw oob", DMEM_CMD_WR, DMEM_WORD, 32'h1000, 32'hCAFEBABE, 32'h0, 1'b1);
    apply_stimulus("t4 w3 rd", DMEM_CMD_RD, DMEM_ILLEGAL, 32'h0, 32'h0, 32'h0, 1'b1);
    apply_stimulus("t4 w3 wr", DMEM_CMD_WR, DMEM_ILLEGAL, 32'h0, 32'h12345678, 32'h0, 1'b1);
    apply_stimulus("t4 lw0", DMEM_CMD_RD, DMEM_WORD, 32'h0, 32'h0, 32'h0BADF00D, 1'b0);
    apply_stimulus("t4 sw top", DMEM_CMD_WR, DMEM_WORD, 32'hFFC, 32'h13579BDF, 32'h0, 1'b0);
    apply_stimulus("t4 lh top", DMEM_CMD_RD, DMEM_HALF, 32'hFFE, 32'h0, 32'h00001357, 1'b0);

    $display("[TB] stall in WAIT and ignored request");
    step();
    drive(1'b1, DMEM_CMD_RD, DMEM_WORD, 32'h10, 32'h0, 1'b0);
    @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      step();
      drive((k == 2), DMEM_CMD_WR, DMEM_WORD, 32'h10, 32'hFFFFFFFF, (k <= 3));
      @(negedge clk);
      check_output($sformatf("t5 resp c+%0d", k), bus.dmem_resp, (k == 5));
    end
    check_output("t5 rdata", bus.dmem_rdata, 32'hA5223344);
    step();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check_output("t5 proto set", bus.proto_err, 1);
    apply_stimulus("t5 lw after", DMEM_CMD_RD, DMEM_WORD, 32'h10, 32'h0, 32'hA5223344, 1'b0);
    check_output("t5 proto sticky", bus.proto_err, 1);

    $display("[TB] reset during WAIT");
    step();
    drive(1'b1, DMEM_CMD_RD, DMEM_WORD, 32'h10, 32'h0, 1'b0);
    @(negedge clk);
    step();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_output("t6 rst resp", bus.dmem_resp, 0);
    check_output("t6 rst proto", bus.proto_err, 0);
    step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output($sformatf("t6 no resp %0d", k), bus.dmem_resp, 0);
    end
    apply_stimulus("t6 lw", DMEM_CMD_RD, DMEM_WORD, 32'h10, 32'h0, 32'hA5223344, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 16; i++) fill_word(32'(4 * i));
    fill_word(32'hFF8);
    fill_word(32'hFFC);
    for (int i = 0; i < 1500; i++) begin
      step();
      st  = ($urandom_range(0, 5) == 0);
      can = !m_pending || ((m_due == cyc + 1) && !st);
      if (can && ($urandom_range(0, 3) != 0)) begin
        wsel = $urandom_range(0, 15);
        w = (wsel == 0) ? DMEM_ILLEGAL : 2'(wsel % 3);
        r = $urandom_range(0, 19);
        if (r < 16) a = 32'(4 * r);
        else if (r == 16) a = 32'hFFC;
        else if (r == 17) a = 32'h1000 + 32'(4 * $urandom_range(0, 255));
        else if (r == 18) a = ($urandom & 32'hFFFF_FFFC) | 32'h8000_0000;
        else a = 32'hFF8;
        if (w == DMEM_BYTE || w == DMEM_ILLEGAL) a = a + 32'($urandom_range(0, 3));
        else if (w == DMEM_HALF) a = a + 32'(2 * $urandom_range(0, 1));
        drive(1'b1, 1'($urandom_range(0, 1)), w, a, $urandom, st);
      end else begin
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, st);
      end
    end
    step();
    drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
    for (int k = 0; k < 20 && m_pending; k++) @(negedge clk);
    @(negedge clk);
    check_output("drain pending", m_pending, 0);
    check_output("final proto_err", bus.proto_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
